// File: rtl/dac_spi_driver.sv
// dac_spi_driver: serialises 12-bit interpolator samples into 16-bit
// MCP4921 SPI frames, each followed by an LDACn latch pulse.
module dac_spi_driver #(
    parameter int unsigned CLK_DIV     = 2,
    parameter logic [3:0]  CFG_BITS    = 4'b0011,
    parameter int unsigned LDAC_CYCLES = 2
) (
    input  logic        Fg_CLK,
    input  logic        RESETn,
    input  logic        Enable,
    input  logic [11:0] interpOut,
    output logic        DAC_CSn,
    output logic        DAC_SCLK,
    output logic        DAC_SDI,
    output logic        DAC_LDACn,
    output logic        Busy,
    output logic        Overrun
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SHIFT   = 2'd1;
    localparam logic [1:0] S_CS_HIGH = 2'd2;
    localparam logic [1:0] S_LDAC    = 2'd3;

    localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);
    localparam logic [3:0] LDAC_LAST = 4'(LDAC_CYCLES - 1);

    logic [1:0]  r_state;
    logic        r_armed;
    logic [3:0]  r_div;
    logic [3:0]  r_bit;
    logic [15:0] r_shift;
    logic        r_pend_v;
    logic [11:0] r_pend_d;
    logic        r_csn;
    logic        r_sclk;
    logic        r_sdi;
    logic        r_ldacn;
    logic        r_busy;
    logic        r_ovr;

    logic        w_idle_free;
    logic        w_load;
    logic [11:0] w_load_data;
    logic        w_div_done;
    logic        w_last_fall;

    // r_armed marks the cycle between the load edge and entering SHIFT;
    // it is treated like a busy cycle for incoming samples.
    assign w_idle_free = (r_state == S_IDLE) && !r_armed;
    assign w_load      = w_idle_free && (r_pend_v || Enable);
    assign w_load_data = r_pend_v ? r_pend_d : interpOut;
    assign w_div_done  = (r_div == DIV_LAST);
    assign w_last_fall = w_div_done && r_sclk && (r_bit == 4'd15);

    // Pending buffer: holds one sample arriving while a frame is active.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_pend_v <= 1'b0;
            r_pend_d <= '0;
            r_ovr    <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_idle_free) begin
                if (r_pend_v) begin
                    r_pend_v <= Enable;
                    if (Enable) begin
                        r_pend_d <= interpOut;
                    end
                end
            end else if (Enable) begin
                r_pend_v <= 1'b1;
                r_pend_d <= interpOut;
                r_ovr    <= r_pend_v;
            end
        end
    end

    // Frame sequencer: state, shared divider/width counter, bit index.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
            r_div   <= '0;
            r_bit   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_armed) begin
                        r_armed <= 1'b0;
                        r_state <= S_SHIFT;
                        r_div   <= '0;
                        r_bit   <= '0;
                    end else if (w_load) begin
                        r_armed <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_div_done) begin
                        r_div <= '0;
                        if (r_sclk) begin
                            if (r_bit == 4'd15) begin
                                r_state <= S_CS_HIGH;
                            end else begin
                                r_bit <= r_bit + 4'd1;
                            end
                        end
                    end else begin
                        r_div <= r_div + 4'd1;
                    end
                end
                S_CS_HIGH: begin
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_state <= S_LDAC;
                    end else begin
                        r_div <= r_div + 4'd1;
                    end
                end
                S_LDAC: begin
                    if (r_div == LDAC_LAST) begin
                        r_div   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Shift register and SDI: MSB presented on entering SHIFT, next bit on each fall.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_shift <= '0;
            r_sdi   <= 1'b0;
        end else if (w_idle_free && w_load) begin
            r_shift <= {CFG_BITS, w_load_data};
        end else if ((r_state == S_IDLE) && r_armed) begin
            r_sdi <= r_shift[15];
        end else if ((r_state == S_SHIFT) && w_div_done && r_sclk) begin
            if (w_last_fall) begin
                r_shift <= '0;
                r_sdi   <= 1'b0;
            end else begin
                r_shift <= {r_shift[14:0], 1'b0};
                r_sdi   <= r_shift[14];
            end
        end
    end

    // SCLK toggles at each divider wrap while shifting; it idles low.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_sclk <= 1'b0;
        end else if ((r_state == S_SHIFT) && w_div_done) begin
            r_sclk <= ~r_sclk;
        end else if (r_state != S_SHIFT) begin
            r_sclk <= 1'b0;
        end
    end

    // Chip select and Busy span the frame; Busy also covers CS recovery and LDAC.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_csn  <= 1'b1;
            r_busy <= 1'b0;
        end else if ((r_state == S_IDLE) && r_armed) begin
            r_csn  <= 1'b0;
            r_busy <= 1'b1;
        end else if ((r_state == S_SHIFT) && w_last_fall) begin
            r_csn <= 1'b1;
        end else if ((r_state == S_LDAC) && (r_div == LDAC_LAST)) begin
            r_busy <= 1'b0;
        end
    end

    // LDACn pulses low for the whole LDAC state.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_ldacn <= 1'b1;
        end else if ((r_state == S_CS_HIGH) && w_div_done) begin
            r_ldacn <= 1'b0;
        end else if ((r_state == S_LDAC) && (r_div == LDAC_LAST)) begin
            r_ldacn <= 1'b1;
        end
    end

    assign DAC_CSn   = r_csn;
    assign DAC_SCLK  = r_sclk;
    assign DAC_SDI   = r_sdi;
    assign DAC_LDACn = r_ldacn;
    assign Busy      = r_busy;
    assign Overrun   = r_ovr;

endmodule

// File: doc/dac_spi_driver.md
Name: dac_spi_driver

Overview:
Output stage of the DDS chain, directly downstream of the interpolator. It captures the 12-bit interpolator sample on each Enable strobe and serialises it as a 16-bit SPI frame to an MCP4921-class DAC. The frame is followed by an LDACn pulse. A one-deep pending buffer absorbs a sample that arrives while a frame is in flight, and the block flags overrun when that buffer is overwritten.

Parameters:
CLK_DIV, 2, Fg_CLK cycles per SCLK half-period; SCLK = Fg_CLK/(2*CLK_DIV), which is 6 MHz at 24 MHz. Legal range 1..15.
CFG_BITS, 4'b0011, frame bits [15:12]: A/B=0, BUF=0, GA=1, SHDN=1.
LDAC_CYCLES, 2, LDACn low width in Fg_CLK cycles. Legal range 1..15.

Ports:
Fg_CLK  in  1  system clock, 24 MHz
RESETn  in  1  asynchronous active-low reset
Enable  in  1  sample strobe from sampling_control; one cycle wide
interpOut  in  12  interpolator sample, unsigned; valid while Enable=1
DAC_CSn  out  1  DAC chip select, active low
DAC_SCLK  out  1  serial clock; idles low (SPI mode 0)
DAC_SDI  out  1  serial data, MSB first
DAC_LDACn  out  1  DAC latch strobe, active low
Busy  out  1  high while a frame, CS recovery or LDAC pulse is in progress
Overrun  out  1  one-cycle pulse when the pending sample is overwritten

Behaviour:
- Reset: RESETn low asynchronously forces outputs and state as follows, including mid-frame:
  - DAC_CSn=1, DAC_SCLK=0, DAC_SDI=0, DAC_LDACn=1, Busy=0, Overrun=0.
  - FSM goes to IDLE; pending buffer is cleared; shift register is cleared.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, SHIFT, CS_HIGH, LDAC.
- IDLE, pending buffer full: load {CFG_BITS, pending}; the pending buffer is emptied.
- IDLE, Enable=1 in the same cycle as a pending load: interpOut is written into the pending buffer. This is not an overrun.
- IDLE, pending empty and Enable=1: load {CFG_BITS, interpOut}.
- Load timing: call the load edge "edge 0". After edge 1 the FSM is in SHIFT with DAC_CSn=0, DAC_SDI=bit15, DAC_SCLK=0, Busy=1.
- SHIFT: a divider counts CLK_DIV cycles per half-period.
  - SCLK rises after edge 1+CLK_DIV*(2k+1) and falls after edge 1+CLK_DIV*(2k+2), for k=0..15.
  - SDI advances to the next bit on each SCLK fall, except the 16th fall.
  - Exactly 16 rising edges per frame. SDI is stable for CLK_DIV cycles on both sides of every rising edge.
- After the 16th fall: DAC_CSn=1, SDI=0, state goes to CS_HIGH for CLK_DIV cycles.
- Then LDAC: DAC_LDACn=0 for LDAC_CYCLES cycles.
- Then IDLE with Busy=0.
- Frame length with defaults: CSn low 64 cycles, CS_HIGH 2 cycles, LDACn low 2 cycles; Busy high 68 cycles.
- Enable with Busy=1:
  - If the pending buffer is empty, interpOut is stored there.
  - If the pending buffer is full, it is overwritten with the newest sample and Overrun=1 for the next cycle.
  - The frame in flight is never disturbed.
- Enable on the same cycle the FSM enters IDLE is handled by the IDLE rules. A pending sample starts its frame with no idle gap: the load edge is the first IDLE cycle.
- interpOut is sampled only when Enable=1; it is ignored otherwise.

Test Plan:
- Single sample: reset 10 cycles, then Enable with interpOut=12'hA5C → SDI shifts 16'h3A5C MSB first; 16 SCLK rises; CSn low 64 cycles; LDACn low 2 cycles after CSn has been high 2 cycles; Busy high 68 cycles; Overrun stays 0.
- Back-to-back: Enable with 12'h123, then 20 cycles later Enable with 12'h456 → frame 16'h3123, then frame 16'h3456 loaded in the first IDLE cycle; no Overrun.
- Overrun: Enables with 12'h001, 12'h002 and 12'h003 within one frame → frames 16'h3001 then 16'h3003 only; Overrun pulses exactly once, for one cycle.
- Boundaries: interpOut 12'h000 then 12'hFFF → frames 16'h3000 and 16'h3FFF; SDI holds the correct level for the full bit time.
- Reset mid-frame: assert RESETn low at the 7th SCLK rise → CSn=1, SCLK=0, LDACn=1, Busy=0 immediately. After release and no Enable, no frame is generated and the pending sample is discarded.
- Instance with CLK_DIV=1 and LDAC_CYCLES=1, Enable with 12'h800 → SCLK = 12 MHz; CSn low 32 cycles; Busy high 34 cycles; frame 16'h3800.
